// File: rtl/lfsr_uart_tx.sv
// Serialises LFSR bytes as 8N1 frames (8E1 when LFSR_UART_PARITY_EN is defined) behind a one-byte hold buffer.
// Latency: start bit drives TX one cycle after the accepting edge when idle, or gaplessly after the previous stop bit.
// Backpressure: READY low while the hold buffer is full; bytes offered then are discarded and flagged on DROP.
module lfsr_uart_tx #(
    parameter int CLK_DIV = 104
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [7:0] I,
    input  logic       VALID,
    output logic       READY,
    output logic       TX,
    output logic       BUSY,
    output logic       DROP
);
    localparam int CW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);

    generate
        if (CLK_DIV < 2) begin : g_bad_div
            $error("lfsr_uart_tx: CLK_DIV must be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] baud_cnt, baud_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    data_q, data_nxt;
    logic [7:0]    hold_dat, hold_nxt;
    logic          hold_full, hold_full_nxt;
    logic          tx_q, tx_nxt;
    logic          drop_q, drop_nxt;
    logic          baud_end;
    logic          load;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            data_q    <= '0;
            hold_dat  <= '0;
            hold_full <= 1'b0;
            tx_q      <= 1'b1;
            drop_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_idx   <= bit_nxt;
            data_q    <= data_nxt;
            hold_dat  <= hold_nxt;
            hold_full <= hold_full_nxt;
            tx_q      <= tx_nxt;
            drop_q    <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        baud_nxt      = baud_cnt + 1'b1;
        bit_nxt       = bit_idx;
        data_nxt      = data_q;
        hold_nxt      = hold_dat;
        hold_full_nxt = hold_full;
        tx_nxt        = tx_q;
        drop_nxt      = VALID && hold_full;
        baud_end      = (baud_cnt == BAUD_LAST);
        load          = 1'b0;

        // Accept and transfer are mutually exclusive: one needs hold empty, the other hold full.
        if (VALID && !hold_full) begin
            hold_full_nxt = 1'b1;
            hold_nxt      = I;
        end

        case (state)
            IDLE: begin
                baud_nxt = '0;
                tx_nxt   = 1'b1;
                load     = hold_full;
            end
            START: begin
                if (baud_end) begin
                    state_nxt = DATA;
                    baud_nxt  = '0;
                    bit_nxt   = 3'd0;
                    tx_nxt    = data_q[0];
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_nxt = '0;
                    if (bit_idx == 3'd7) begin
`ifdef LFSR_UART_PARITY_EN
                        state_nxt = PARITY;
                        tx_nxt    = ^data_q;
`else
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                        tx_nxt  = data_q[bit_idx + 3'd1];
                    end
                end
            end
`ifdef LFSR_UART_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    state_nxt = STOP;
                    baud_nxt  = '0;
                    tx_nxt    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    state_nxt = IDLE;
                    baud_nxt  = '0;
                    tx_nxt    = 1'b1;
                    load      = hold_full;
                end
            end
            default: begin
                state_nxt = IDLE;
                baud_nxt  = '0;
                tx_nxt    = 1'b1;
            end
        endcase

        // Shifter load overrides the state decision so back-to-back frames have no idle gap.
        if (load) begin
            state_nxt     = START;
            baud_nxt      = '0;
            bit_nxt       = 3'd0;
            data_nxt      = hold_dat;
            hold_full_nxt = 1'b0;
            tx_nxt        = 1'b0;
        end
    end

    assign READY = !hold_full;
    assign TX    = tx_q;
    assign BUSY  = (state != IDLE);
    assign DROP  = drop_q;

endmodule

// File: tb/tb_lfsr_uart_tx.sv
// Bench for lfsr_uart_tx: directed scenarios plus random offers, each cycle checked against a frame-timeline model.
// Model tracks frame start edges and hold-release edges arithmetically; TX is looked up from the expected frame bits.
module tb_lfsr_uart_tx;
    localparam int DIV = 4;
`ifdef LFSR_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * DIV;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic [7:0] I = 8'h00;
    logic       VALID = 1'b0;
    logic       READY, TX, BUSY, DROP;

    int n_tests = 0;
    int n_fail  = 0;

    lfsr_uart_tx #(.CLK_DIV(DIV)) dut (
        .CLK(CLK), .RESETN(RESETN), .I(I), .VALID(VALID),
        .READY(READY), .TX(TX), .BUSY(BUSY), .DROP(DROP)
    );

    always #5 CLK = ~CLK;

    // Model state: current frame start edge and byte, pending hold byte and the edge it moves to the shifter.
    int         e = 0;
    int         cs = -1000;
    logic [7:0] cb = 8'h00;
    bit         hp = 0;
    logic [7:0] hb = 8'h00;
    int         rp = 0;
    int         n_drops = 0;
    int         n_frames = 0;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, e, obs, exp);
        end
    endtask

    task automatic step(input bit rst_n, input bit v, input logic [7:0] d);
        bit          dropped;
        bit          was_full;
        bit          exp_busy;
        logic        exp_tx;
        logic [10:0] fb;
        @(negedge CLK);
        RESETN = rst_n;
        VALID  = v;
        I      = d;
        @(posedge CLK);
        #1;
        e++;
        dropped = 0;
        if (!rst_n) begin
            cs = -1000;
            hp = 0;
        end else begin
            was_full = hp;
            if (hp && e == rp) begin
                cs = e;
                cb = hb;
                hp = 0;
                n_frames++;
            end
            if (v) begin
                if (was_full) begin
                    dropped = 1;
                    n_drops++;
                end else begin
                    hp = 1;
                    hb = d;
                    rp = (e < cs + FL) ? cs + FL : e + 1;
                end
            end
        end
        exp_busy = (e >= cs) && (e < cs + FL);
        fb = 11'h7FF;
        fb[0] = 1'b0;
        fb[8:1] = cb;
`ifdef LFSR_UART_PARITY_EN
        fb[9] = ^cb;
`endif
        exp_tx = exp_busy ? fb[(e - cs) / DIV] : 1'b1;
        check("tx",    TX,    exp_tx);
        check("busy",  BUSY,  exp_busy);
        check("ready", READY, !hp);
        check("drop",  DROP,  dropped);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 8'h00);
    endtask

    initial begin
        int base;
        logic [7:0] rb;
        // Reset state.
        step(0, 0, 8'h00);
        step(0, 1, 8'h5A);
        idle(3);

        // Single 0xA5 frame: start, LSB-first data, stop, then idle.
        step(1, 1, 8'hA5);
        idle(FL + 6);

        // Back-to-back 0x01 then 0x80 offered mid-frame: no idle gap between frames.
        step(1, 1, 8'h01);
        idle(10);
        step(1, 1, 8'h80);
        idle(2 * FL + 4);

        // Offers at relative cycles 0, 5, 6: third one is dropped.
        base = n_drops;
        step(1, 1, 8'h11);
        idle(4);
        step(1, 1, 8'h22);
        step(1, 1, 8'h33);
        idle(2 * FL + 4);
        check("drop_count_t3", (n_drops - base) == 1, 1'b1);

        // Reset at cycle 15 of a 0x00 frame truncates it; line stays idle afterwards.
        step(1, 1, 8'h00);
        idle(14);
        step(0, 0, 8'h00);
        idle(50);

        // Parity-sensitive bytes (odd and even popcount).
        step(1, 1, 8'h07);
        idle(FL + 2);
        step(1, 1, 8'h03);
        idle(FL + 2);

        // VALID held high continuously: gapless frames, drops while hold is full.
        base = n_drops;
        for (int k = 0; k < 100; k++) step(1, 1, 8'hFF);
        idle(2 * FL + 4);
        check("saturate_drops", (n_drops - base) > 80, 1'b1);

        // Random offers with varying density and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            int dens;
            dens = (k / 500) % 3 == 0 ? 3 : ((k / 500) % 3 == 1 ? 30 : 90);
            rb = 8'($urandom);
            if ($urandom_range(0, 799) == 0) step(0, 0, 8'h00);
            else step(1, $urandom_range(0, 99) < dens, rb);
        end
        idle(2 * FL + 4);
        check("frames_seen", n_frames > 40, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
